rf_wb_arbiter: RTL and testbench

Writeback arbiter and sequencer for the 64-entry, 16-bit register file. Collects write requests from NSRC execution sources (ALU, load unit, link/branch), holds each in a one-entry buffer, and schedules up to two per cycle onto the register file's two write ports under round-robin priority. Same-register collisions between the ports are prevented. The block sits between the execute/memory stages and the register file write ports.

---
 rtl/rf_pkg.sv | 31 +++
 rtl/rf_rr_pick.sv | 60 ++++++
 rtl/rf_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback path.
// Holds the default widths, request bundle and source index names.
package rf_pkg;

    localparam int RF_AW   = 6;
    localparam int RF_DW   = 16;
    localparam int RF_NSRC = 3;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } rf_wb_req_t;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_LINK = 2'd2
    } rf_src_e;

    // Increment an index modulo n.
    function automatic int unsigned rf_wrap_inc(
        input int unsigned i,
        input int unsigned n
    );
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rf_rr_pick.sv
// Round-robin first/second pick over pending writeback buffers.
// Port 2 never takes a source aimed at the port 1 register.
module rf_rr_pick
    import rf_pkg::*;
#(
    parameter int NSRC = RF_NSRC,
    parameter int AW   = RF_AW,
    parameter int IW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0]    i_pend,
    input  logic [IW-1:0]      i_rr,
    input  logic [NSRC*AW-1:0] i_addr,
    output logic [NSRC-1:0]    o_grant,
    output logic               o_p1_vld,
    output logic               o_p2_vld,
    output logic [IW-1:0]      o_p1_idx,
    output logic [IW-1:0]      o_p2_idx
);

    logic [NSRC-1:0] w_grant;
    logic            w_v1;
    logic            w_v2;
    logic [IW-1:0]   w_i1;
    logic [IW-1:0]   w_i2;
    logic [AW-1:0]   w_a1;
    int              w_idx;

    // Scan from rr upward: first pending takes port 1, next distinct-address one port 2.
    always_comb begin
        w_grant = '0;
        w_v1    = 1'b0;
        w_v2    = 1'b0;
        w_i1    = '0;
        w_i2    = '0;
        w_a1    = '0;
        w_idx   = 0;
        for (int k = 0; k < NSRC; k++) begin
            w_idx = (int'(i_rr) + k) % NSRC;
            if (i_pend[w_idx]) begin
                if (!w_v1) begin
                    w_v1           = 1'b1;
                    w_i1           = IW'(w_idx);
                    w_a1           = i_addr[w_idx*AW +: AW];
                    w_grant[w_idx] = 1'b1;
                end else if (!w_v2 && (i_addr[w_idx*AW +: AW] != w_a1)) begin
                    w_v2           = 1'b1;
                    w_i2           = IW'(w_idx);
                    w_grant[w_idx] = 1'b1;
                end
            end
        end
    end

    assign o_grant  = w_grant;
    assign o_p1_vld = w_v1;
    assign o_p2_vld = w_v2;
    assign o_p1_idx = w_i1;
    assign o_p2_idx = w_i2;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: per-source one-entry buffers scheduled onto two RF write ports.
// Optional RF_WB_FWD_EN adds combinational forwarding from the write ports.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NSRC = RF_NSRC,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NSRC-1:0]    src_valid,
    output logic [NSRC-1:0]    src_ready,
    input  logic [NSRC*AW-1:0] src_addr,
    input  logic [NSRC*DW-1:0] src_data,
`ifdef RF_WB_FWD_EN
    input  logic [AW-1:0]      reg_rd1,
    input  logic [AW-1:0]      reg_rd2,
    input  logic [AW-1:0]      reg_rd3,
    output logic               fwd_hit1,
    output logic               fwd_hit2,
    output logic               fwd_hit3,
    output logic [DW-1:0]      fwd_data1,
    output logic [DW-1:0]      fwd_data2,
    output logic [DW-1:0]      fwd_data3,
`endif
    output logic [AW-1:0]      reg_wr1,
    output logic [AW-1:0]      reg_wr2,
    output logic [DW-1:0]      reg_wr1_data,
    output logic [DW-1:0]      reg_wr2_data,
    output logic               reg_wr1_enable,
    output logic               reg_wr2_enable,
    output logic               idle
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0]    r_pend;
    logic [AW-1:0]      r_addr [NSRC];
    logic [DW-1:0]      r_data [NSRC];
    logic [IW-1:0]      r_rr;
    logic [AW-1:0]      r_wr1;
    logic [AW-1:0]      r_wr2;
    logic [DW-1:0]      r_wr1_data;
    logic [DW-1:0]      r_wr2_data;
    logic               r_en1;
    logic               r_en2;

    logic [NSRC*AW-1:0] w_addr_flat;
    logic [NSRC-1:0]    w_grant;
    logic [NSRC-1:0]    w_hs;
    logic               w_p1_vld;
    logic               w_p2_vld;
    logic [IW-1:0]      w_p1_idx;
    logic [IW-1:0]      w_p2_idx;
    logic [IW-1:0]      w_last;
    logic [IW-1:0]      w_rr_nxt;

    // Flatten buffered addresses for the picker.
    always_comb begin
        w_addr_flat = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_addr_flat[i*AW +: AW] = r_addr[i];
        end
    end

    rf_rr_pick #(
        .NSRC (NSRC),
        .AW   (AW),
        .IW   (IW)
    ) u_pick (
        .i_pend   (r_pend),
        .i_rr     (r_rr),
        .i_addr   (w_addr_flat),
        .o_grant  (w_grant),
        .o_p1_vld (w_p1_vld),
        .o_p2_vld (w_p2_vld),
        .o_p1_idx (w_p1_idx),
        .o_p2_idx (w_p2_idx)
    );

    assign src_ready = reset ? '0 : (~r_pend | w_grant);
    assign w_hs      = src_valid & src_ready;
    assign w_last    = w_p2_vld ? w_p2_idx : w_p1_idx;
    assign w_rr_nxt  = IW'(rf_wrap_inc(32'(w_last), 32'(NSRC)));

    // Buffer load/clear, pointer advance and write-port registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend     <= '0;
            r_rr       <= '0;
            r_wr1      <= '0;
            r_wr2      <= '0;
            r_wr1_data <= '0;
            r_wr2_data <= '0;
            r_en1      <= 1'b0;
            r_en2      <= 1'b0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (w_hs[i]) begin
                    r_pend[i] <= 1'b1;
                    r_addr[i] <= src_addr[i*AW +: AW];
                    r_data[i] <= src_data[i*DW +: DW];
                end else if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
            if (w_p1_vld) begin
                r_wr1      <= r_addr[w_p1_idx];
                r_wr1_data <= r_data[w_p1_idx];
                r_rr       <= w_rr_nxt;
            end
            if (w_p2_vld) begin
                r_wr2      <= r_addr[w_p2_idx];
                r_wr2_data <= r_data[w_p2_idx];
            end
            r_en1 <= w_p1_vld;
            r_en2 <= w_p2_vld;
        end
    end

    assign reg_wr1        = r_wr1;
    assign reg_wr2        = r_wr2;
    assign reg_wr1_data   = r_wr1_data;
    assign reg_wr2_data   = r_wr2_data;
    assign reg_wr1_enable = r_en1;
    assign reg_wr2_enable = r_en2;
    assign idle           = ~|r_pend & ~r_en1 & ~r_en2;

`ifdef RF_WB_FWD_EN
    logic [DW:0] w_f1;
    logic [DW:0] w_f2;
    logic [DW:0] w_f3;

    // Forward from the live write ports, port 1 taking precedence.
    function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] rd);
        if (r_en1 && (r_wr1 == rd)) begin
            return {1'b1, r_wr1_data};
        end
        if (r_en2 && (r_wr2 == rd)) begin
            return {1'b1, r_wr2_data};
        end
        return '0;
    endfunction

    // Three read-port compares against the registered write ports.
    always_comb begin
        w_f1 = fwd_lookup(reg_rd1);
        w_f2 = fwd_lookup(reg_rd2);
        w_f3 = fwd_lookup(reg_rd3);
    end

    assign {fwd_hit1, fwd_data1} = w_f1;
    assign {fwd_hit2, fwd_data2} = w_f2;
    assign {fwd_hit3, fwd_data3} = w_f3;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter with a queue-free behavioural model.
// Build with RF_WB_FWD_EN to also exercise the forwarding outputs.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int NSRC = 3;
    localparam int AW   = 6;
    localparam int DW   = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NSRC-1:0]   src_valid = '0;
    logic [NSRC-1:0]   src_ready;
    logic [NSRC*AW-1:0] src_addr = '0;
    logic [NSRC*DW-1:0] src_data = '0;
    logic [AW-1:0]     reg_wr1, reg_wr2;
    logic [DW-1:0]     reg_wr1_data, reg_wr2_data;
    logic              reg_wr1_enable, reg_wr2_enable;
    logic              idle;
`ifdef RF_WB_FWD_EN
    logic [AW-1:0]     reg_rd1 = '0, reg_rd2 = '0, reg_rd3 = '0;
    logic              fwd_hit1, fwd_hit2, fwd_hit3;
    logic [DW-1:0]     fwd_data1, fwd_data2, fwd_data3;
`endif

    rf_wb_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_addr       (src_addr),
        .src_data       (src_data),
`ifdef RF_WB_FWD_EN
        .reg_rd1        (reg_rd1),
        .reg_rd2        (reg_rd2),
        .reg_rd3        (reg_rd3),
        .fwd_hit1       (fwd_hit1),
        .fwd_hit2       (fwd_hit2),
        .fwd_hit3       (fwd_hit3),
        .fwd_data1      (fwd_data1),
        .fwd_data2      (fwd_data2),
        .fwd_data3      (fwd_data3),
`endif
        .reg_wr1        (reg_wr1),
        .reg_wr2        (reg_wr2),
        .reg_wr1_data   (reg_wr1_data),
        .reg_wr2_data   (reg_wr2_data),
        .reg_wr1_enable (reg_wr1_enable),
        .reg_wr2_enable (reg_wr2_enable),
        .idle           (idle)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state.
    logic [NSRC-1:0] m_pend = '0;
    logic [AW-1:0]   m_a [NSRC];
    logic [DW-1:0]   m_d [NSRC];
    int              m_rr = 0;
    logic            e_en1 = 0, e_en2 = 0;
    logic [AW-1:0]   e_a1 = '0, e_a2 = '0;
    logic [DW-1:0]   e_d1 = '0, e_d2 = '0;
    logic [DW-1:0]   m_rf [64];
    logic [DW-1:0]   d_rf [64];

    // Register file as seen through the DUT write ports.
    always @(posedge clock) begin
        if (reg_wr1_enable) d_rf[reg_wr1] <= reg_wr1_data;
        if (reg_wr2_enable) d_rf[reg_wr2] <= reg_wr2_data;
    end

    function automatic void pick(output int p1, output int p2);
        p1 = -1;
        p2 = -1;
        for (int k = 0; k < NSRC; k++) begin
            int s = (m_rr + k) % NSRC;
            if (m_pend[s]) begin
                if (p1 < 0) p1 = s;
                else if (p2 < 0 && m_a[s] != m_a[p1]) p2 = s;
            end
        end
    endfunction

    function automatic logic [NSRC-1:0] exp_ready();
        int p1, p2;
        logic [NSRC-1:0] r;
        if (reset) return '0;
        pick(p1, p2);
        r = ~m_pend;
        if (p1 >= 0) r[p1] = 1'b1;
        if (p2 >= 0) r[p2] = 1'b1;
        return r;
    endfunction

    function automatic logic exp_idle();
        return (m_pend == '0) && !e_en1 && !e_en2;
    endfunction

    // Advance one clock, updating the model from the pre-edge state.
    task automatic tick();
        int p1, p2;
        logic [NSRC-1:0] hs;
        pick(p1, p2);
        hs = src_valid & exp_ready();
        @(posedge clock);
        if (reset) begin
            m_pend = '0;
            m_rr = 0;
            e_en1 = 0; e_en2 = 0;
            e_a1 = '0; e_a2 = '0;
            e_d1 = '0; e_d2 = '0;
        end else begin
            e_en1 = (p1 >= 0);
            e_en2 = (p2 >= 0);
            if (p1 >= 0) begin
                e_a1 = m_a[p1]; e_d1 = m_d[p1];
                m_rf[e_a1] = e_d1;
                m_rr = (p1 + 1) % NSRC;
            end
            if (p2 >= 0) begin
                e_a2 = m_a[p2]; e_d2 = m_d[p2];
                m_rf[e_a2] = e_d2;
                m_rr = (p2 + 1) % NSRC;
            end
            for (int s = 0; s < NSRC; s++) begin
                if (hs[s]) begin
                    m_pend[s] = 1'b1;
                    m_a[s] = src_addr[s*AW +: AW];
                    m_d[s] = src_data[s*DW +: DW];
                end else if (s == p1 || s == p2) begin
                    m_pend[s] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        src_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if (src_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 000", src_ready);
        end
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_chk++;
        if ({reg_wr1_enable, reg_wr2_enable} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_en: got %b want 00", {reg_wr1_enable, reg_wr2_enable});
        end
        n_chk++;
        if ({reg_wr1, reg_wr2, reg_wr1_data, reg_wr2_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_ports: got %h %h %h %h want 0", reg_wr1, reg_wr2, reg_wr1_data, reg_wr2_data);
        end
        n_chk++;
        if (idle !== 1'b1 || src_ready !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_idle: idle %b ready %b want 1 111", idle, src_ready);
        end
    endtask

    task automatic test_single();
        src_addr[0*AW +: AW] = 6'd5;
        src_data[0*DW +: DW] = 16'h1234;
        src_valid = 3'b001;
        tick();
        src_valid = '0;
        n_chk++;
        if (reg_wr1_enable !== 1'b0 || idle !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pend: en1 %b idle %b want 0 0", reg_wr1_enable, idle);
        end
        tick();
        n_chk++;
        if (reg_wr1_enable !== 1'b1 || reg_wr1 !== 6'd5 || reg_wr1_data !== 16'h1234 || reg_wr2_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL single_write: en1 %b a %0d d %h en2 %b want 1 5 1234 0",
                     reg_wr1_enable, reg_wr1, reg_wr1_data, reg_wr2_enable);
        end
        tick();
        n_chk++;
        if (idle !== 1'b1 || reg_wr1_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: idle %b en1 %b want 1 0", idle, reg_wr1_enable);
        end
        n_chk++;
        if (d_rf[5] !== 16'h1234) begin
            n_fail++;
            $display("FAIL single_rf: got %h want 1234", d_rf[5]);
        end
    endtask

    task automatic test_contention();
        int t1[3] = '{1, 3, 2};
        int t2[3] = '{2, 1, 3};
        do_reset();
        src_addr = {6'd3, 6'd2, 6'd1};
        src_valid = 3'b111;
        for (int c = 0; c < 10; c++) begin
            src_data = {16'($urandom), 16'($urandom), 16'($urandom)};
            tick();
            if (c >= 1) begin
                n_chk++;
                if (reg_wr1_enable !== 1'b1 || reg_wr2_enable !== 1'b1 ||
                    reg_wr1 !== 6'(t1[(c-1)%3]) || reg_wr2 !== 6'(t2[(c-1)%3])) begin
                    n_fail++;
                    $display("FAIL contention_order c%0d: en %b%b a %0d,%0d want 11 %0d,%0d",
                             c, reg_wr1_enable, reg_wr2_enable, reg_wr1, reg_wr2,
                             t1[(c-1)%3], t2[(c-1)%3]);
                end
                n_chk++;
                if (reg_wr1_data !== e_d1 || reg_wr2_data !== e_d2) begin
                    n_fail++;
                    $display("FAIL contention_data c%0d: got %h %h want %h %h",
                             c, reg_wr1_data, reg_wr2_data, e_d1, e_d2);
                end
            end
        end
        src_valid = '0;
        repeat (4) tick();
    endtask

    task automatic test_collision();
        do_reset();
        src_addr[0*AW +: AW] = 6'd7;
        src_addr[1*AW +: AW] = 6'd7;
        src_data[0*DW +: DW] = 16'hAAAA;
        src_data[1*DW +: DW] = 16'hBBBB;
        src_valid = 3'b011;
        tick();
        src_valid = '0;
        tick();
        n_chk++;
        if (reg_wr1_enable !== 1'b1 || reg_wr1 !== 6'd7 || reg_wr1_data !== 16'hAAAA || reg_wr2_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_first: en %b%b a %0d d %h want 10 7 aaaa",
                     reg_wr1_enable, reg_wr2_enable, reg_wr1, reg_wr1_data);
        end
        tick();
        n_chk++;
        if (!((reg_wr1_enable === 1'b1 && reg_wr1 === 6'd7 && reg_wr1_data === 16'hBBBB) ||
              (reg_wr2_enable === 1'b1 && reg_wr2 === 6'd7 && reg_wr2_data === 16'hBBBB))) begin
            n_fail++;
            $display("FAIL collision_second: a %0d/%0d d %h/%h want 7 bbbb", reg_wr1, reg_wr2, reg_wr1_data, reg_wr2_data);
        end
        tick();
        n_chk++;
        if (d_rf[7] !== 16'hBBBB || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_final: rf %h idle %b want bbbb 1", d_rf[7], idle);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] seq[3] = '{6'd10, 6'd11, 6'd12};
        do_reset();
        src_valid = 3'b100;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                src_addr[2*AW +: AW] = seq[c];
                src_data[2*DW +: DW] = 16'h0C00 + 16'(c);
                #1;
                n_chk++;
                if (src_ready[2] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready c%0d: got %b want 1", c, src_ready[2]);
                end
            end else begin
                src_valid = '0;
            end
            tick();
            if (c >= 1 && c <= 3) begin
                n_chk++;
                if (reg_wr1_enable !== 1'b1 || reg_wr1 !== seq[c-1] || reg_wr1_data !== 16'h0C00 + 16'(c-1)) begin
                    n_fail++;
                    $display("FAIL b2b_write c%0d: en %b a %0d d %h want 1 %0d %h",
                             c, reg_wr1_enable, reg_wr1, reg_wr1_data, seq[c-1], 16'h0C00 + 16'(c-1));
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        src_addr = {6'd0, 6'd21, 6'd20};
        src_data = {16'h0, 16'h2121, 16'h2020};
        src_valid = 3'b011;
        tick();
        src_valid = '0;
        reset = 1'b1;
        #1;
        n_chk++;
        if (src_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_ready: got %b want 000", src_ready);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_chk++;
            if (reg_wr1_enable !== 1'b0 || reg_wr2_enable !== 1'b0 || idle !== 1'b1) begin
                n_fail++;
                $display("FAIL midrst_quiet c%0d: en %b%b idle %b want 00 1",
                         c, reg_wr1_enable, reg_wr2_enable, idle);
            end
            tick();
        end
        n_chk++;
        if (d_rf[20] !== 16'h0 || d_rf[21] !== 16'h0) begin
            n_fail++;
            $display("FAIL midrst_stale: got %h %h want 0 0", d_rf[20], d_rf[21]);
        end
        src_addr = {6'd32, 6'd31, 6'd30};
        src_valid = 3'b111;
        tick();
        src_valid = '0;
        tick();
        n_chk++;
        if (reg_wr1 !== 6'd30 || reg_wr2 !== 6'd31 || reg_wr1_enable !== 1'b1 || reg_wr2_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_rr: a %0d %0d want 30 31", reg_wr1, reg_wr2);
        end
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            src_valid = 3'($urandom);
            for (int s = 0; s < NSRC; s++) begin
                src_addr[s*AW +: AW] = 6'($urandom_range(0, 5));
                src_data[s*DW +: DW] = 16'($urandom);
            end
            #1;
            n_chk++;
            if (src_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL rand_ready c%0d: got %b want %b", c, src_ready, exp_ready());
            end
            tick();
            n_chk++;
            if (reg_wr1_enable !== e_en1 || reg_wr2_enable !== e_en2 ||
                reg_wr1 !== e_a1 || reg_wr2 !== e_a2 ||
                reg_wr1_data !== e_d1 || reg_wr2_data !== e_d2) begin
                n_fail++;
                $display("FAIL rand_ports c%0d: got %b%b %0d %0d %h %h want %b%b %0d %0d %h %h",
                         c, reg_wr1_enable, reg_wr2_enable, reg_wr1, reg_wr2, reg_wr1_data, reg_wr2_data,
                         e_en1, e_en2, e_a1, e_a2, e_d1, e_d2);
            end
            n_chk++;
            if (reg_wr1_enable && reg_wr2_enable && reg_wr1 === reg_wr2) begin
                n_fail++;
                $display("FAIL rand_same_addr c%0d: both ports at %0d want distinct", c, reg_wr1);
            end
            n_chk++;
            if (idle !== exp_idle()) begin
                n_fail++;
                $display("FAIL rand_idle c%0d: got %b want %b", c, idle, exp_idle());
            end
        end
        src_valid = '0;
        repeat (5) tick();
        for (int a = 0; a < 64; a++) begin
            n_chk++;
            if (d_rf[a] !== m_rf[a]) begin
                n_fail++;
                $display("FAIL rand_rf[%0d]: got %h want %h", a, d_rf[a], m_rf[a]);
            end
        end
    endtask

`ifdef RF_WB_FWD_EN
    task automatic test_fwd();
        do_reset();
        src_addr = {6'd0, 6'd9, 6'd4};
        src_data = {16'h0, 16'h0F0F, 16'h1111};
        src_valid = 3'b011;
        tick();
        src_valid = '0;
        tick();
        reg_rd1 = 6'd33;
        reg_rd2 = 6'd34;
        reg_rd3 = 6'd9;
        #1;
        n_chk++;
        if (fwd_hit3 !== 1'b1 || fwd_data3 !== 16'h0F0F || reg_wr2 !== 6'd9) begin
            n_fail++;
            $display("FAIL fwd_hit3: hit %b d %h want 1 0f0f", fwd_hit3, fwd_data3);
        end
        n_chk++;
        if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0 || fwd_data1 !== 16'h0 || fwd_data2 !== 16'h0) begin
            n_fail++;
            $display("FAIL fwd_miss: hit %b%b d %h %h want 00 0 0", fwd_hit1, fwd_hit2, fwd_data1, fwd_data2);
        end
        reg_rd1 = 6'd4;
        #1;
        n_chk++;
        if (fwd_hit1 !== 1'b1 || fwd_data1 !== 16'h1111) begin
            n_fail++;
            $display("FAIL fwd_hit1: hit %b d %h want 1 1111", fwd_hit1, fwd_data1);
        end
        repeat (2) tick();
    endtask
`endif

    initial begin
        for (int a = 0; a < 64; a++) begin
            m_rf[a] = '0;
            d_rf[a] = '0;
        end
        test_reset();
        test_single();
        test_contention();
        test_collision();
        test_back_to_back();
        test_reset_midflight();
        test_random();
`ifdef RF_WB_FWD_EN
        test_fwd();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
